svo_tmds_stream: RTL and testbench

- Downstream consumer of the video-encoder AXI stream (pixel data plus tuser {blank, vsync, hsync, sof}).
- Converts one beat per clk into three 10-bit TMDS symbols (blue/green/red channels) for the serializer/OSER stage.
- Fixed 3-stage pipeline, DVI 1.0 TMDS 8b/10b with per-channel running disparity.
- Detects stream underflow and resynchronises on start of frame.

---
 rtl/svo_tmds_stream.sv | 201 ++++++++++++++++++++
 tb/tb_svo_tmds_stream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/svo_tmds_stream.sv
// AXI-stream pixels to three DVI TMDS 10-bit symbols with per-channel running disparity.
// Three-stage fixed pipeline. SVO_TMDS_UNDERFLOW_COUNT_EN adds a saturating underflow counter.
module svo_tmds_stream #(
   parameter int   SVO_BITS_PER_PIXEL = 24,
   parameter logic HSYNC_POL          = 1'b0,
   parameter logic VSYNC_POL          = 1'b0
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          in_axis_tvalid,
   output logic                          in_axis_tready,
   input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
   input  logic [3:0]                    in_axis_tuser,
   output logic [9:0]                    tmds_ch0,
   output logic [9:0]                    tmds_ch1,
   output logic [9:0]                    tmds_ch2,
   output logic                          locked,
   output logic                          underflow
`ifdef SVO_TMDS_UNDERFLOW_COUNT_EN
   ,
   output logic [15:0]                   underflow_count,
   input  logic                          underflow_clear
`endif
);

   localparam logic       STATE_SEARCH = 1'b0;
   localparam logic       STATE_RUN    = 1'b1;
   localparam logic [9:0] CTRL_00      = 10'b1101010100;

   function automatic logic [3:0] popcount8(input logic [7:0] d);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'd0, d[i]};
      return n;
   endfunction

   function automatic logic [8:0] qm_calc(input logic [7:0] d, input logic [3:0] n);
      logic       use_xnor;
      logic [8:0] q;
      use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
      q        = 9'd0;
      q[0]     = d[0];
      for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8]     = ~use_xnor;
      return q;
   endfunction

   function automatic logic [9:0] ctrl_code(input logic [1:0] c);
      logic [9:0] s;
      case (c)
         2'b00:   s = 10'b1101010100;
         2'b01:   s = 10'b0010101011;
         2'b10:   s = 10'b0101010100;
         default: s = 10'b1010101011;
      endcase
      return s;
   endfunction

   // Returns {next running disparity, symbol}; disparity is ones minus zeros of emitted symbols.
   function automatic logic [14:0] tmds_enc(input logic [8:0] qm, input logic [3:0] n1,
                                            input logic [4:0] cnt);
      logic signed [4:0] c;
      logic signed [4:0] diff;
      logic signed [4:0] cn;
      logic signed [5:0] d6;
      logic        [9:0] sym;
      c    = $signed(cnt);
      d6   = $signed({1'b0, n1, 1'b0}) - 6'sd8;
      diff = d6[4:0];
      if ((c == 5'sd0) || (n1 == 4'd4)) begin
         sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cn  = qm[8] ? (c + diff) : (c - diff);
      end else if (((c > 5'sd0) && (n1 > 4'd4)) || ((c < 5'sd0) && (n1 < 4'd4))) begin
         sym = {1'b1, qm[8], ~qm[7:0]};
         cn  = c + (qm[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
         sym = {1'b0, qm[8], qm[7:0]};
         cn  = c + diff - (qm[8] ? 5'sd0 : 5'sd2);
      end
      return {cn, sym};
   endfunction

   logic        tready_q, tready_d;
   logic        state_q, state_d;
   logic        s1_blank_q, s1_blank_d;
   logic [1:0]  s1_ctl_q, s1_ctl_d;
   logic [23:0] s1_dat_q, s1_dat_d;
   logic [11:0] s1_pc_q, s1_pc_d;
   logic        s2_blank_q, s2_blank_d;
   logic [1:0]  s2_ctl_q, s2_ctl_d;
   logic [26:0] s2_qm_q, s2_qm_d;
   logic [11:0] s2_pc_q, s2_pc_d;
   logic [29:0] sym_q, sym_d;
   logic [14:0] cnt_q, cnt_d;
   logic [14:0] enc;
   logic        take;

   always_comb begin
      take     = tready_q & in_axis_tvalid & ((state_q == STATE_RUN) | in_axis_tuser[0]);
      tready_d = 1'b1;
      state_d  = state_q;
      if (take)
         state_d = STATE_RUN;
      else if (state_q == STATE_RUN)
         state_d = STATE_SEARCH;

      // Slots without an accepted beat carry the idle symbol: blank, both syncs inactive.
      s1_blank_d = 1'b1;
      s1_ctl_d   = {~VSYNC_POL, ~HSYNC_POL};
      s1_dat_d   = 24'd0;
      if (take) begin
         s1_blank_d = in_axis_tuser[3];
         s1_ctl_d   = {in_axis_tuser[2] ? VSYNC_POL : ~VSYNC_POL,
                       in_axis_tuser[1] ? HSYNC_POL : ~HSYNC_POL};
         s1_dat_d   = in_axis_tdata[23:0];
      end
      s1_pc_d = 12'd0;
      for (int ch = 0; ch < 3; ch++) s1_pc_d[ch*4 +: 4] = popcount8(s1_dat_d[ch*8 +: 8]);

      s2_blank_d = s1_blank_q;
      s2_ctl_d   = s1_ctl_q;
      s2_qm_d    = 27'd0;
      s2_pc_d    = 12'd0;
      for (int ch = 0; ch < 3; ch++) begin
         s2_qm_d[ch*9 +: 9] = qm_calc(s1_dat_q[ch*8 +: 8], s1_pc_q[ch*4 +: 4]);
         s2_pc_d[ch*4 +: 4] = popcount8(s2_qm_d[ch*9 +: 8]);
      end

      sym_d = 30'd0;
      cnt_d = 15'd0;
      enc   = 15'd0;
      if (s2_blank_q) begin
         sym_d = {CTRL_00, CTRL_00, ctrl_code(s2_ctl_q)};
      end else begin
         for (int ch = 0; ch < 3; ch++) begin
            enc                  = tmds_enc(s2_qm_q[ch*9 +: 9], s2_pc_q[ch*4 +: 4], cnt_q[ch*5 +: 5]);
            sym_d[ch*10 +: 10]   = enc[9:0];
            cnt_d[ch*5 +: 5]     = enc[14:10];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         tready_q   <= 1'b0;
         state_q    <= STATE_SEARCH;
         s1_blank_q <= 1'b1;
         s1_ctl_q   <= 2'b00;
         s1_dat_q   <= 24'd0;
         s1_pc_q    <= 12'd0;
         s2_blank_q <= 1'b1;
         s2_ctl_q   <= 2'b00;
         s2_qm_q    <= 27'd0;
         s2_pc_q    <= 12'd0;
         sym_q      <= {CTRL_00, CTRL_00, CTRL_00};
         cnt_q      <= 15'd0;
      end else begin
         tready_q   <= tready_d;
         state_q    <= state_d;
         s1_blank_q <= s1_blank_d;
         s1_ctl_q   <= s1_ctl_d;
         s1_dat_q   <= s1_dat_d;
         s1_pc_q    <= s1_pc_d;
         s2_blank_q <= s2_blank_d;
         s2_ctl_q   <= s2_ctl_d;
         s2_qm_q    <= s2_qm_d;
         s2_pc_q    <= s2_pc_d;
         sym_q      <= sym_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_axis_tready = tready_q;
   assign locked         = resetn & take;
   assign underflow      = resetn & (state_q == STATE_RUN) & ~in_axis_tvalid;
   assign tmds_ch0       = sym_q[9:0];
   assign tmds_ch1       = sym_q[19:10];
   assign tmds_ch2       = sym_q[29:20];

`ifdef SVO_TMDS_UNDERFLOW_COUNT_EN
   logic [15:0] ucnt_q, ucnt_d;

   always_comb begin
      ucnt_d = ucnt_q;
      if (underflow_clear)
         ucnt_d = 16'd0;
      else if (underflow && (ucnt_q != 16'hFFFF))
         ucnt_d = ucnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         ucnt_q <= 16'd0;
      else
         ucnt_q <= ucnt_d;
   end

   assign underflow_count = ucnt_q;
`endif

endmodule

// File: tb/tb_svo_tmds_stream.sv
// Randomized scoreboard bench for svo_tmds_stream against a behavioural TMDS/stream model.
module tb_svo_tmds_stream;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        tvalid = 1'b0;
   logic [23:0] tdata = 24'd0;
   logic [3:0]  tuser = 4'd0;
   logic        uclr = 1'b0;
   logic        tready, locked, underflow;
   logic [9:0]  ch0, ch1, ch2;
`ifdef SVO_TMDS_UNDERFLOW_COUNT_EN
   logic [15:0] ucount;
`endif

   always #5 clk = ~clk;

   svo_tmds_stream dut (
      .clk            (clk),
      .resetn         (resetn),
      .in_axis_tvalid (tvalid),
      .in_axis_tready (tready),
      .in_axis_tdata  (tdata),
      .in_axis_tuser  (tuser),
      .tmds_ch0       (ch0),
      .tmds_ch1       (ch1),
      .tmds_ch2       (ch2),
      .locked         (locked),
      .underflow      (underflow)
`ifdef SVO_TMDS_UNDERFLOW_COUNT_EN
      ,
      .underflow_count(ucount),
      .underflow_clear(uclr)
`endif
   );

   typedef struct {
      int         due;
      logic [9:0] c0;
      logic [9:0] c1;
      logic [9:0] c2;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   mcnt[3];
   bit   m_run = 0, m_rdy = 0;
   bit   imm_on = 0, tready_on = 0;
   logic e_tready, e_locked, e_uf;
   int   m_ucnt = 0, e_ucnt = 0;
   bit   ucnt_on = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, req);
      end
   endtask

   function automatic logic [9:0] ctl(input logic [1:0] c);
      case (c)
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   // Plain-arithmetic DVI encoder; mcnt[ch] is the running disparity (ones minus zeros).
   task automatic enc_ch(input logic [7:0] d, input int ch, output logic [9:0] sym);
      int         n, n1, n0, c;
      bit         xn, b8;
      logic [7:0] q;
      n    = $countones(d);
      xn   = (n > 4) || (n == 4 && d[0] == 1'b0);
      q    = 8'd0;
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      b8 = !xn;
      n1 = $countones(q);
      n0 = 8 - n1;
      c  = mcnt[ch];
      if (c == 0 || n1 == n0) begin
         sym = {~b8, b8, b8 ? q : ~q};
         c   = c + (b8 ? n1 - n0 : n0 - n1);
      end else if ((c > 0 && n1 > n0) || (c < 0 && n0 > n1)) begin
         sym = {1'b1, b8, ~q};
         c   = c + (b8 ? 2 : 0) + n0 - n1;
      end else begin
         sym = {1'b0, b8, q};
         c   = c - (b8 ? 0 : 2) + n1 - n0;
      end
      mcnt[ch] = c;
   endtask

   task automatic push_beat(input bit take, input logic [23:0] d, input logic [3:0] u);
      exp_t e;
      e.due = cyc + 3;
      if (!take || u[3]) begin
         // Active-low syncs: an active sync emits 0, an inactive one emits 1.
         e.c0 = take ? ctl({~u[2], ~u[1]}) : ctl(2'b11);
         e.c1 = ctl(2'b00);
         e.c2 = ctl(2'b00);
         mcnt = '{0, 0, 0};
      end else begin
         enc_ch(d[7:0], 0, e.c0);
         enc_ch(d[15:8], 1, e.c1);
         enc_ch(d[23:16], 2, e.c2);
      end
      sb.push_back(e);
   endtask

   task automatic slot(input logic rn, input logic v, input logic [23:0] d,
                       input logic [3:0] u, input logic clr);
      bit   take, uf;
      exp_t e;
      @(posedge clk);
      #1;
      resetn = rn;
      tvalid = v;
      tdata  = d;
      tuser  = u;
      uclr   = clr;
      if (!rn) begin
         while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
         for (int i = 1; i <= 3; i++) begin
            e.due = cyc + i;
            e.c0  = ctl(2'b00);
            e.c1  = ctl(2'b00);
            e.c2  = ctl(2'b00);
            sb.push_back(e);
         end
         e_locked  = 1'b0;
         e_uf      = 1'b0;
         tready_on = 0;
         ucnt_on   = 0;
         m_run     = 0;
         m_rdy     = 0;
         m_ucnt    = 0;
         mcnt      = '{0, 0, 0};
      end else begin
         e_tready  = m_rdy;
         tready_on = 1;
         take      = 0;
         uf        = 0;
         if (m_run) begin
            if (v) take = 1;
            else begin
               uf    = 1;
               m_run = 0;
            end
         end else if (m_rdy && v && u[0]) begin
            take  = 1;
            m_run = 1;
         end
         e_locked = take;
         e_uf     = uf;
         push_beat(take, d, u);
         m_rdy    = 1;
         e_ucnt   = m_ucnt;
         ucnt_on  = 1;
         if (clr) m_ucnt = 0;
         else if (uf && m_ucnt < 65535) m_ucnt++;
      end
      imm_on = 1;
   endtask

   always @(negedge clk) begin
      if (imm_on) begin
         if (tready_on) check("tready", {15'd0, tready}, {15'd0, e_tready});
         check("locked", {15'd0, locked}, {15'd0, e_locked});
         check("underflow", {15'd0, underflow}, {15'd0, e_uf});
`ifdef SVO_TMDS_UNDERFLOW_COUNT_EN
         if (ucnt_on) check("underflow_count", ucount, e_ucnt[15:0]);
`endif
      end
      while (sb.size() > 0 && sb[0].due < cyc) begin
         vectors++;
         miscompares++;
         $display("FAIL symbol_missed cycle %0d: got no check, expected due %0d", cyc, sb[0].due);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         exp_t e;
         e = sb.pop_front();
         check("tmds_ch0", {6'd0, ch0}, {6'd0, e.c0});
         check("tmds_ch1", {6'd0, ch1}, {6'd0, e.c1});
         check("tmds_ch2", {6'd0, ch2}, {6'd0, e.c2});
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of stimulus, expected finish");
      $fatal(1, "timeout");
   end

   function automatic logic [3:0] rnd_user(input int blank_pct);
      logic [3:0] u;
      u    = 4'd0;
      u[3] = ($urandom_range(99) < blank_pct);
      u[2] = $urandom_range(1);
      u[1] = $urandom_range(1);
      return u;
   endfunction

   initial begin
      logic [23:0] px;
      int          left;

      repeat (4) slot(0, 0, 24'd0, 4'd0, 0);
      repeat (3) slot(1, 0, 24'd0, 4'd0, 0);
      repeat (5) slot(1, 1, 24'($urandom), rnd_user(50), 0);
      slot(1, 1, 24'($urandom), 4'b1101, 0);
      repeat (4) slot(1, 1, 24'($urandom), 4'b1000, 0);
      slot(1, 1, 24'h000000, 4'b0000, 0);
      slot(1, 1, 24'hFFFFFF, 4'b0000, 0);

      for (int i = 0; i < 640; i++) begin
         px = {8'($urandom), 8'h55, 8'($urandom)};
         slot(1, 1, px, 4'b0000, 0);
      end
      repeat (8) slot(1, 1, 24'($urandom), 4'b1010, 0);

      for (int i = 0; i < 1000; i++) begin
         logic [3:0] u;
         u    = rnd_user(0);
         u[3] = ((i % 100) >= 90);
         slot(1, 1, 24'($urandom), u, 0);
      end

      slot(1, 0, 24'd0, 4'd0, 0);
      repeat (6) slot(1, 1, 24'($urandom), 4'b0000, 0);
      slot(1, 1, 24'($urandom), 4'b0001, 0);
      repeat (20) slot(1, 1, 24'($urandom), 4'b0000, 0);
      slot(1, 1, 24'($urandom), 4'b0001, 0);
      repeat (5) slot(1, 1, 24'($urandom), 4'b0000, 0);

      for (int i = 0; i < 400; i++) begin
         logic [3:0] u;
         u    = rnd_user(10);
         u[0] = ($urandom_range(7) == 0);
         slot(1, ($urandom_range(9) != 0), 24'($urandom), u, ($urandom_range(49) == 0));
      end

      slot(1, 1, 24'($urandom), 4'b0001, 0);
      repeat (10) slot(1, 1, 24'($urandom), 4'b0000, 0);
      repeat (3) slot(0, 1, 24'($urandom), 4'b0000, 0);
      repeat (2) slot(1, 1, 24'($urandom), 4'b0000, 0);
      slot(1, 1, 24'($urandom), 4'b1001, 0);
      repeat (10) slot(1, 1, 24'($urandom), 4'b0000, 0);
      repeat (3) slot(1, 0, 24'd0, 4'd0, 0);

      @(posedge clk);
      #1;
      imm_on = 0;
      repeat (5) @(posedge clk);
      #1;
      left = sb.size();
      check("scoreboard_drained", left[15:0], 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
